// File: rtl/cnn_pkg.sv
// Shared CNN helpers: pool FSM states, accumulator width rule and DW-bit signed saturation.
// No logic or storage of its own; used by accum_maxpool and its pool datapath.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        POOL  = 2'd2,
        DRAIN = 2'd3
    } pool_state_t;

    localparam int SAT_W = 64;

    // Wide enough for NIN*NPASS partial sums plus the bias without any intermediate wrap.
    function automatic int acc_width(input int dw, input int nin, input int npass);
        return dw + $clog2(nin * npass + 1) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] v,
                                                      input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/max2_signed.sv
// Combinational signed maximum of two DW-bit samples; zero latency, no flow control.
// On a tie either input is returned, which is the same value.
module max2_signed #(
    parameter int DW = 12
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] y
);

    assign y = (a > b) ? a : b;

endmodule

// File: rtl/accum_maxpool.sv
// Accumulates NPASS full-map passes of NIN-lane partial sums plus bias, then 2x2 max-pools; ACCUM_MAXPOOL_RELU_EN adds ReLU.
// Latency 3 cycles window issue to out_valid; in_ready low outside IDLE/ACCUM; out_valid&&!out_ready freezes the pool pipe.
module accum_maxpool
    import cnn_pkg::*;
#(
    parameter int DW    = 12,
    parameter int MAP_W = 10,
    parameter int MAP_H = 6,
    parameter int NIN   = 2,
    parameter int NPASS = 3
) (
    input  logic                 cnn_clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIN*DW-1:0]    in_data,
    input  logic signed [DW-1:0] bias,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int ACC_W  = acc_width(DW, NIN, NPASS);
    localparam int NPIX   = MAP_W * MAP_H;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int PASS_W = $clog2(NPASS + 1);
    localparam int WC_W   = $clog2(MAP_W / 2 + 1);
    localparam int WR_W   = $clog2(MAP_H / 2 + 1);

    if (MAP_W < 2 || (MAP_W % 2) != 0 || MAP_H < 2 || (MAP_H % 2) != 0) begin : g_bad_map
        $fatal(1, "accum_maxpool: MAP_W and MAP_H must be even and non-zero");
    end

    pool_state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [PASS_W-1:0] pass_q;
    logic [WR_W-1:0]   win_r_q;
    logic [WC_W-1:0]   win_c_q;

    logic in_fire, map_end, last_pass, stall, win_issue, last_win;

    logic signed [ACC_W-1:0] acc_mem [NPIX];
    logic signed [ACC_W-1:0] lane_sum, acc_base, bias_term, acc_wr;

    logic [ADDR_W-1:0]     rd_base;
    logic [ADDR_W-1:0]     rd_addr [4];
    logic signed [DW-1:0]  pix_sat [4];
    logic signed [DW-1:0]  s1_pix  [4];
    logic signed [DW-1:0]  row_max0, row_max1, fin_max;
    logic signed [DW-1:0]  s2_row0, s2_row1;
    logic                  s1_vld, s1_last, s2_vld, s2_last;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign in_fire   = in_valid && in_ready;
    assign map_end   = (addr_q == ADDR_W'(NPIX - 1));
    assign last_pass = (pass_q == PASS_W'(NPASS - 1));
    assign stall     = out_valid && !out_ready;
    assign win_issue = (state_q == POOL) && !stall;
    assign last_win  = (win_r_q == WR_W'(MAP_H / 2 - 1)) && (win_c_q == WC_W'(MAP_W / 2 - 1));

    always_ff @(posedge cnn_clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_fire)
                    state_d = (map_end && last_pass) ? POOL : ACCUM;
            end
            ACCUM: begin
                if (in_fire && map_end && last_pass)
                    state_d = POOL;
            end
            POOL: begin
                if (win_issue && last_win)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cnn_clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            pass_q  <= '0;
            win_r_q <= '0;
            win_c_q <= '0;
        end else begin
            if (in_fire) begin
                if (map_end) begin
                    addr_q <= '0;
                    pass_q <= last_pass ? '0 : pass_q + PASS_W'(1);
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            if (win_issue) begin
                if (last_win) begin
                    win_r_q <= '0;
                    win_c_q <= '0;
                end else if (win_c_q == WC_W'(MAP_W / 2 - 1)) begin
                    win_c_q <= '0;
                    win_r_q <= win_r_q + WR_W'(1);
                end else begin
                    win_c_q <= win_c_q + WC_W'(1);
                end
            end
        end
    end

    // Pass 0 ignores the stored value, so an abandoned frame never needs clearing.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NIN; i++)
            lane_sum = lane_sum + ACC_W'($signed(in_data[i*DW +: DW]));
        acc_base  = (pass_q == '0) ? '0 : acc_mem[addr_q];
        bias_term = last_pass ? ACC_W'(bias) : '0;
        acc_wr    = acc_base + lane_sum + bias_term;
    end

    always_ff @(posedge cnn_clk) begin
        if (in_fire)
            acc_mem[addr_q] <= acc_wr;
    end

    always_comb begin
        rd_base    = ADDR_W'(2 * MAP_W) * ADDR_W'(win_r_q) + ADDR_W'(2) * ADDR_W'(win_c_q);
        rd_addr[0] = rd_base;
        rd_addr[1] = rd_base + ADDR_W'(1);
        rd_addr[2] = rd_base + ADDR_W'(MAP_W);
        rd_addr[3] = rd_base + ADDR_W'(MAP_W + 1);
        for (int k = 0; k < 4; k++) begin
            pix_sat[k] = DW'(sat_dw(SAT_W'(acc_mem[rd_addr[k]]), DW));
`ifdef ACCUM_MAXPOOL_RELU_EN
            if (pix_sat[k] < 0)
                pix_sat[k] = '0;
`endif
        end
    end

    max2_signed #(.DW(DW)) u_row0 (.a(s1_pix[0]), .b(s1_pix[1]), .y(row_max0));
    max2_signed #(.DW(DW)) u_row1 (.a(s1_pix[2]), .b(s1_pix[3]), .y(row_max1));
    max2_signed #(.DW(DW)) u_fin  (.a(s2_row0),   .b(s2_row1),   .y(fin_max));

    // Stages: saturated pixels -> row maxima -> final maximum; all advance together.
    always_ff @(posedge cnn_clk) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s2_vld    <= 1'b0;
            s2_last   <= 1'b0;
            s2_row0   <= '0;
            s2_row1   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < 4; k++)
                s1_pix[k] <= '0;
        end else if (!stall) begin
            s1_vld  <= win_issue;
            s1_last <= win_issue && last_win;
            for (int k = 0; k < 4; k++)
                s1_pix[k] <= pix_sat[k];
            s2_vld    <= s1_vld;
            s2_last   <= s1_vld && s1_last;
            s2_row0   <= row_max0;
            s2_row1   <= row_max1;
            out_valid <= s2_vld;
            out_last  <= s2_vld && s2_last;
            out_data  <= fin_max;
        end
    end

endmodule

// File: tb/tb_accum_maxpool.sv
// Directed frames against a pixel-level model of accumulate, saturate, optional ReLU and 2x2 max-pool.
module tb_accum_maxpool;

    localparam int DW    = 12;
    localparam int MAP_W = 10;
    localparam int MAP_H = 6;
    localparam int NIN   = 2;
    localparam int NPASS = 3;
    localparam int NPIX  = MAP_W * MAP_H;
    localparam int NWIN  = (MAP_W / 2) * (MAP_H / 2);

    logic                 cnn_clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [NIN*DW-1:0]    in_data;
    logic signed [DW-1:0] bias;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic                 busy;

    always #5 cnn_clk = ~cnn_clk;

    accum_maxpool #(.DW(DW), .MAP_W(MAP_W), .MAP_H(MAP_H), .NIN(NIN), .NPASS(NPASS)) dut (
        .cnn_clk  (cnn_clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .bias     (bias),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    int nvec = 0;
    int nerr = 0;
    int exp_q[$];
    int exp_last_q[$];
    int out_cnt;
    int first_out;
    bit prev_stall = 1'b0;
    logic signed [DW-1:0] prev_data;
    logic prev_last;

`ifdef ACCUM_MAXPOOL_RELU_EN
    localparam int WIN_NEG = 0;
`else
    localparam int WIN_NEG = -4;
`endif

    task automatic chk(input string name, input int act, input int exp_v);
        nvec++;
        if (act != exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int lane_val(input int mode, input int pass, input int pix, input int lane);
        case (mode)
            0: return 1;
            1: begin
                if (pass != 0 || lane != 0) return 0;
                case (pix)
                    0:       return -5;
                    1:       return -3;
                    MAP_W:   return -9;
                    MAP_W+1: return -7;
                    default: return -20;
                endcase
            end
            2: return 2047;
            default: return ((pix * 7 + pass * 13 + lane * 5) % 41) - 20;
        endcase
    endfunction

    function automatic int sat_relu(input int v);
        int s;
        s = (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
`ifdef ACCUM_MAXPOOL_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic build_expected(input int mode, input int b);
        int px[NPIX];
        int m, p, idx;
        for (int pix = 0; pix < NPIX; pix++) begin
            int s;
            s = b;
            for (int ps = 0; ps < NPASS; ps++)
                for (int ln = 0; ln < NIN; ln++)
                    s += lane_val(mode, ps, pix, ln);
            px[pix] = sat_relu(s);
        end
        idx = 0;
        for (int r = 0; r < MAP_H / 2; r++) begin
            for (int c = 0; c < MAP_W / 2; c++) begin
                p = 2 * r * MAP_W + 2 * c;
                m = px[p];
                if (px[p + 1] > m)         m = px[p + 1];
                if (px[p + MAP_W] > m)     m = px[p + MAP_W];
                if (px[p + MAP_W + 1] > m) m = px[p + MAP_W + 1];
                exp_q.push_back(m);
                exp_last_q.push_back((idx == NWIN - 1) ? 1 : 0);
                idx++;
            end
        end
    endtask

    task automatic drive_beat(input int mode, input int pass, input int pix);
        in_valid = 1'b1;
        for (int ln = 0; ln < NIN; ln++)
            in_data[ln*DW +: DW] = DW'(lane_val(mode, pass, pix, ln));
        @(posedge cnn_clk);
        #1;
    endtask

    always @(negedge cnn_clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(prev_data));
                chk("hold_last", int'(out_last), int'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL extra_output: got %0d, expected no output", out_data);
                end else begin
                    int e, l;
                    e = exp_q.pop_front();
                    l = exp_last_q.pop_front();
                    chk("out_data", int'(out_data), e);
                    chk("out_last", int'(out_last), l);
                    if (out_cnt == 0) first_out = int'(out_data);
                end
                out_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_frame(input int mode, input int b, input bit stall_en,
                             input bit hold_valid, input int exp_first);
        int cyc, lat, stall_left;
        bit done, stalled, start_stall;
        bias      = DW'(b);
        out_cnt   = 0;
        first_out = -99999;
        chk("in_ready_idle", int'(in_ready), 1);
        for (int ps = 0; ps < NPASS; ps++)
            for (int pix = 0; pix < NPIX; pix++)
                drive_beat(mode, ps, pix);
        build_expected(mode, b);
        if (hold_valid)
            in_data = '1;
        else
            in_valid = 1'b0;
        cyc = 0; lat = -1; done = 1'b0; stalled = 1'b0; stall_left = 0;
        while (!done && cyc < 400) begin
            @(negedge cnn_clk);
            #1;
            chk("in_ready_pool", int'(in_ready), 0);
            chk("busy_pool", int'(busy), 1);
            if (out_valid && lat < 0) lat = cyc;
            if (out_valid && out_ready && out_last) done = 1'b1;
            start_stall = stall_en && !stalled && (out_cnt == 4);
            @(posedge cnn_clk);
            #1;
            cyc++;
            if (start_stall) begin
                out_ready  = 1'b0;
                stall_left = 5;
                stalled    = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL frame_timeout: got %0d outputs, expected out_last within 400 cycles", out_cnt);
        end
        chk("first_valid_latency", lat, 3);
        chk("out_count", out_cnt, NWIN);
        chk("queue_empty", exp_q.size(), 0);
        chk("first_out_literal", first_out, exp_first);
        chk("busy_idle", int'(busy), 0);
        exp_q.delete();
        exp_last_q.delete();
        @(posedge cnn_clk);
        #1;
    endtask

    task automatic abort_frame();
        bias = DW'(5);
        for (int bt = 0; bt < 100; bt++)
            drive_beat(3, bt / NPIX, bt % NPIX);
        in_valid = 1'b1;
        rst_n    = 1'b0;
        @(posedge cnn_clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge cnn_clk);
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        bias      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge cnn_clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge cnn_clk);
        #1;

        run_frame(0, 0, 1'b0, 1'b0, 6);
        run_frame(1, -1, 1'b0, 1'b0, WIN_NEG);
        run_frame(2, 2047, 1'b0, 1'b0, 2047);
        run_frame(3, 5, 1'b1, 1'b0, 20);
        abort_frame();
        run_frame(3, -7, 1'b0, 1'b0, 8);
        run_frame(0, 3, 1'b0, 1'b1, 9);
        run_frame(1, -1, 1'b0, 1'b0, WIN_NEG);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
